sh_mtu: RTL



---
 rtl/sh_mtu.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sh_mtu.sv
// sh_mtu: multi-channel compare-match timer, shared prescaler, vectored IRQ.
// Optional input capture when SH_MTU_CAPTURE_EN is defined.
module sh_mtu #(
  parameter int          CHANNELS  = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFE40
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CE_R,
  input  logic                CE_F,
  input  logic                EN,
  input  logic                RES_N,
  input  logic                EXT_CLK,
`ifdef SH_MTU_CAPTURE_EN
  input  logic [CHANNELS-1:0] CAP_IN,
`endif
  output logic [CHANNELS-1:0] TOUT,
  input  logic [31:0]         IBUS_A,
  input  logic [31:0]         IBUS_DI,
  output logic [31:0]         IBUS_DO,
  input  logic [3:0]          IBUS_BA,
  input  logic                IBUS_WE,
  input  logic                IBUS_REQ,
  output logic                IBUS_BUSY,
  output logic                IBUS_ACT,
  output logic                IRQ,
  output logic [7:0]          VEC
);

`ifdef SH_MTU_CAPTURE_EN
  localparam logic [8:0] TCR_MASK = 9'h1F7;
`else
  localparam logic [8:0] TCR_MASK = 9'h0F7;
`endif
  localparam logic [31:0] WIN = 32'((CHANNELS + 1) * 16);

  logic [8:0]          tcr  [CHANNELS];
  logic [CNT_W-1:0]    tcnt [CHANNELS];
  logic [CNT_W-1:0]    tcmp [CHANNELS];
  logic [CNT_W-1:0]    cnt_nx [CHANNELS];
  logic [CNT_W-1:0]    cmp_nx [CHANNELS];
  logic [CHANNELS-1:0] cmf, ovf, tstr, tstr_nx;
  logic [CHANNELS-1:0] wr_ch, tick, match, ovfe, cap;
  logic [CHANNELS-1:0] capm, ie, toe, pend;
  logic [CHANNELS-1:0] cmf_clr, ovf_clr;
  logic [7:0]          tvr, tk_sel;
  logic [9:0]          pre;
  logic                ext_q;
  logic [31:0]         off, bmask;
  logic [CNT_W-1:0]    m_c, d_c;
  logic [3:0]          blk;
  logic [1:0]          rsel;
  logic [2:0]          idx;
  logic                adv, wr, wr_g;
  logic                unused;

  assign off       = IBUS_A - BASE_ADDR;
  assign blk       = off[7:4];
  assign rsel      = off[3:2];
  assign IBUS_ACT  = IBUS_REQ && (off < WIN);
  assign IBUS_BUSY = 1'b0;
  assign adv       = CE_R && EN;
  assign wr        = adv && IBUS_ACT && IBUS_WE;
  assign wr_g      = wr && (blk == 4'(CHANNELS));
  assign bmask     = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}},
                      {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}};
  assign m_c       = bmask[CNT_W-1:0];
  assign d_c       = IBUS_DI[CNT_W-1:0];
  assign pend      = ie & (cmf | ovf);
  assign unused    = ^{CE_F, off[31:8], IBUS_DI, bmask};

  // Tick per clock select; /2^k fires when the low k prescaler bits are all 1.
  assign tk_sel = {1'b0, EXT_CLK & ~ext_q, &pre, &pre[7:0],
                   &pre[5:0], &pre[3:0], &pre[1:0], 1'b1};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_bits
    assign capm[g] = tcr[g][8];
    assign ie[g]   = tcr[g][6];
    assign toe[g]  = tcr[g][7];
  end

`ifdef SH_MTU_CAPTURE_EN
  logic [CHANNELS-1:0] cs1, cs2, cs3;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {cs1, cs2, cs3} <= '0;
    end else if (CE_R && !RES_N) begin
      {cs1, cs2, cs3} <= '0;
    end else if (adv) begin
      cs1 <= CAP_IN;
      cs2 <= cs1;
      cs3 <= cs2;
    end
  end

  assign cap = cs2 & ~cs3 & capm;
`else
  assign cap = '0;
`endif

  always_comb begin
    tstr_nx = tstr;
    for (int n = 0; n < CHANNELS; n++) begin
      wr_ch[n] = wr && (blk == 4'(n));
      tick[n]  = tk_sel[tcr[n][2:0]] && tstr[n];
      match[n] = tick[n] && (tcnt[n] == tcmp[n]) && !capm[n];
      ovfe[n]  = tick[n] && (&tcnt[n]) && !(match[n] && tcr[n][4]);
      cnt_nx[n] = tcnt[n];
      if (tick[n])
        cnt_nx[n] = (match[n] && tcr[n][4]) ? '0 : tcnt[n] + 1'b1;
      // A CPU write to TCNT overrides the count.
      if (wr_ch[n] && rsel == 2'd1)
        cnt_nx[n] = (tcnt[n] & ~m_c) | (d_c & m_c);
      cmp_nx[n] = tcmp[n];
      if (wr_ch[n] && rsel == 2'd2)
        cmp_nx[n] = (tcmp[n] & ~m_c) | (d_c & m_c);
      if (cap[n])
        cmp_nx[n] = tcnt[n];
      cmf_clr[n] = wr_ch[n] && rsel == 2'd3 && IBUS_BA[0] && IBUS_DI[0];
      ovf_clr[n] = wr_ch[n] && rsel == 2'd3 && IBUS_BA[0] && IBUS_DI[1];
      if (match[n] && tcr[n][5])
        tstr_nx[n] = 1'b0;
    end
    if (wr_g && rsel == 2'd0 && IBUS_BA[0])
      tstr_nx = IBUS_DI[CHANNELS-1:0];
  end

  always_comb begin
    idx = '0;
    for (int n = CHANNELS - 1; n >= 0; n--)
      if (pend[n]) idx = 3'(n);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < CHANNELS; n++) begin
        tcr[n]  <= '0;
        tcnt[n] <= '0;
        tcmp[n] <= '0;
      end
      {cmf, ovf, tstr, TOUT} <= '0;
      {tvr, pre, ext_q, IRQ, VEC} <= '0;
    end else if (CE_R && !RES_N) begin
      for (int n = 0; n < CHANNELS; n++) begin
        tcr[n]  <= '0;
        tcnt[n] <= '0;
        tcmp[n] <= '0;
      end
      {cmf, ovf, tstr, TOUT} <= '0;
      {tvr, pre, ext_q, IRQ, VEC} <= '0;
    end else if (adv) begin
      pre   <= pre + 1'b1;
      ext_q <= EXT_CLK;
      tstr  <= tstr_nx;
      cmf   <= (cmf & ~cmf_clr) | match | cap;
      ovf   <= (ovf & ~ovf_clr) | ovfe;
      TOUT  <= TOUT ^ (match & toe);
      for (int n = 0; n < CHANNELS; n++) begin
        tcnt[n] <= cnt_nx[n];
        tcmp[n] <= cmp_nx[n];
        if (wr_ch[n] && rsel == 2'd0)
          tcr[n] <= ((tcr[n] & ~bmask[8:0])
                   | (IBUS_DI[8:0] & bmask[8:0])) & TCR_MASK;
      end
      if (wr_g && rsel == 2'd1 && IBUS_BA[0])
        tvr <= IBUS_DI[7:0];
      IRQ <= |pend;
      if (|pend)
        VEC <= tvr + 8'(idx);
    end
  end

  always_comb begin
    IBUS_DO = '0;
    if (IBUS_ACT) begin
      for (int n = 0; n < CHANNELS; n++)
        if (blk == 4'(n))
          unique case (rsel)
            2'd0: IBUS_DO = 32'(tcr[n]);
            2'd1: IBUS_DO = 32'(tcnt[n]);
            2'd2: IBUS_DO = 32'(tcmp[n]);
            2'd3: IBUS_DO = {30'd0, ovf[n], cmf[n]};
          endcase
      if (blk == 4'(CHANNELS))
        case (rsel)
          2'd0:    IBUS_DO = 32'(tstr);
          2'd1:    IBUS_DO = {24'd0, tvr};
          default: IBUS_DO = '0;
        endcase
    end
  end

endmodule
